// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator: pixel/line counters, sync, blank and end-of-line/frame flags
module vga_timing #(
   parameter int HVID = 640,
   parameter int HFP  = 16,
   parameter int HSW  = 96,
   parameter int HBP  = 48,
   parameter int VVID = 480,
   parameter int VFP  = 10,
   parameter int VSW  = 2,
   parameter int VBP  = 33
) (
   input  logic       clk_25,
   input  logic       rst,
   output logic [9:0] horizontal_num,
   output logic [9:0] vertical_num,
   output logic       hsync,
   output logic       vsync,
   output logic       blank,
   output logic       line_end,
   output logic       frame_end
);

   localparam int HTOTAL = HVID + HFP + HSW + HBP;
   localparam int VTOTAL = VVID + VFP + VSW + VBP;

   // Reject timings that cannot be represented by 10-bit counters or that collapse a phase.
   generate
      if (HTOTAL > 1024 || VTOTAL > 1024 ||
          HVID < 1 || HFP < 1 || HSW < 1 || HBP < 1 ||
          VVID < 1 || VFP < 1 || VSW < 1 || VBP < 1) begin : g_bad_params
         $error("vga_timing: invalid timing parameters");
      end
   endgenerate

   localparam logic [9:0] H_LAST       = 10'(HTOTAL - 1);
   localparam logic [9:0] H_FRONT_AT   = 10'(HVID);
   localparam logic [9:0] H_SYNC_AT    = 10'(HVID + HFP);
   localparam logic [9:0] H_BACK_AT    = 10'(HVID + HFP + HSW);
   localparam logic [9:0] V_LAST       = 10'(VTOTAL - 1);
   localparam logic [9:0] V_FRONT_AT   = 10'(VVID);
   localparam logic [9:0] V_SYNC_AT    = 10'(VVID + VFP);
   localparam logic [9:0] V_BACK_AT    = 10'(VVID + VFP + VSW);

   typedef enum logic [1:0] {H_VIDEO, H_FRONT, H_SYNC, H_BACK} h_phase_t;
   typedef enum logic [1:0] {V_VIDEO, V_FRONT, V_SYNC, V_BACK} v_phase_t;

   h_phase_t   h_phase, h_phase_next;
   v_phase_t   v_phase, v_phase_next;
   logic [9:0] h_next, v_next;
   logic       h_wrap;

   // Next counter values and phase transitions; flags are registered from these so they line up with the counters.
   always_comb begin
      h_wrap       = (horizontal_num == H_LAST);
      h_next       = h_wrap ? 10'd0 : horizontal_num + 10'd1;
      v_next       = vertical_num;
      h_phase_next = h_phase;
      v_phase_next = v_phase;

      if (h_next == 10'd0)             h_phase_next = H_VIDEO;
      else if (h_next == H_FRONT_AT)   h_phase_next = H_FRONT;
      else if (h_next == H_SYNC_AT)    h_phase_next = H_SYNC;
      else if (h_next == H_BACK_AT)    h_phase_next = H_BACK;

      if (h_wrap) begin
         v_next = (vertical_num == V_LAST) ? 10'd0 : vertical_num + 10'd1;
         if (v_next == 10'd0)           v_phase_next = V_VIDEO;
         else if (v_next == V_FRONT_AT) v_phase_next = V_FRONT;
         else if (v_next == V_SYNC_AT)  v_phase_next = V_SYNC;
         else if (v_next == V_BACK_AT)  v_phase_next = V_BACK;
      end
   end

   // Counters, phase state and all output flags, registered together.
   always_ff @(posedge clk_25) begin
      if (rst) begin
         horizontal_num <= 10'd0;
         vertical_num   <= 10'd0;
         h_phase        <= H_VIDEO;
         v_phase        <= V_VIDEO;
         hsync          <= 1'b1;
         vsync          <= 1'b1;
         blank          <= 1'b0;
         line_end       <= 1'b0;
         frame_end      <= 1'b0;
      end else begin
         horizontal_num <= h_next;
         vertical_num   <= v_next;
         h_phase        <= h_phase_next;
         v_phase        <= v_phase_next;
         hsync          <= (h_phase_next != H_SYNC);
         vsync          <= (v_phase_next != V_SYNC);
         blank          <= (h_phase_next != H_VIDEO) || (v_phase_next != V_VIDEO);
         line_end       <= (h_next == H_LAST);
         frame_end      <= (h_next == H_LAST) && (v_next == V_LAST);
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - bench for vga_timing: vector table, random resets against a counting model, corner sequences
module tb_vga_timing;

   // Reduced geometry: HTOTAL=8, VTOTAL=5.
   localparam int R_HVID = 4, R_HFP = 1, R_HSW = 2, R_HBP = 1;
   localparam int R_VVID = 2, R_VFP = 1, R_VSW = 1, R_VBP = 1;

   logic       clk_25 = 1'b0;
   logic       rst_d = 1'b1, rst_r = 1'b1;
   logic [9:0] h_d, v_d, h_r, v_r;
   logic       hs_d, vs_d, bl_d, le_d, fe_d;
   logic       hs_r, vs_r, bl_r, le_r, fe_r;

   int total = 0;
   int bad   = 0;

   always #20 clk_25 = ~clk_25;

   vga_timing dut_d (
      .clk_25(clk_25), .rst(rst_d),
      .horizontal_num(h_d), .vertical_num(v_d),
      .hsync(hs_d), .vsync(vs_d), .blank(bl_d),
      .line_end(le_d), .frame_end(fe_d)
   );

   vga_timing #(
      .HVID(R_HVID), .HFP(R_HFP), .HSW(R_HSW), .HBP(R_HBP),
      .VVID(R_VVID), .VFP(R_VFP), .VSW(R_VSW), .VBP(R_VBP)
   ) dut_r (
      .clk_25(clk_25), .rst(rst_r),
      .horizontal_num(h_r), .vertical_num(v_r),
      .hsync(hs_r), .vsync(vs_r), .blank(bl_r),
      .line_end(le_r), .frame_end(fe_r)
   );

   typedef struct {
      int inst;   // 0 = default geometry, 1 = reduced
      int n;      // counting edges after the reset edge
      int h, v, hs, vs, bl, le, fe;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int inst, input int n, input int h, input int v,
                      input int hs, input int vs, input int bl, input int le, input int fe);
      vec_t e;
      e.inst = inst; e.n = n; e.h = h; e.v = v;
      e.hs = hs; e.vs = vs; e.bl = bl; e.le = le; e.fe = fe;
      vecs.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int inst, input int h, input int v,
                            input int hs, input int vs, input int bl, input int le, input int fe);
      if (inst == 0) begin
         chk({tag, "_h"}, int'(h_d), h);   chk({tag, "_v"}, int'(v_d), v);
         chk({tag, "_hs"}, int'(hs_d), hs); chk({tag, "_vs"}, int'(vs_d), vs);
         chk({tag, "_bl"}, int'(bl_d), bl); chk({tag, "_le"}, int'(le_d), le);
         chk({tag, "_fe"}, int'(fe_d), fe);
      end else begin
         chk({tag, "_h"}, int'(h_r), h);   chk({tag, "_v"}, int'(v_r), v);
         chk({tag, "_hs"}, int'(hs_r), hs); chk({tag, "_vs"}, int'(vs_r), vs);
         chk({tag, "_bl"}, int'(bl_r), bl); chk({tag, "_le"}, int'(le_r), le);
         chk({tag, "_fe"}, int'(fe_r), fe);
      end
   endtask

   // Raster position after k counting edges, with every flag taken straight from the window rules.
   task automatic model(input int k, input int hv, input int hf, input int hsw, input int hb,
                        input int vv, input int vf, input int vsw, input int vb,
                        output int eh, output int ev, output int ehs, output int evs,
                        output int ebl, output int ele, output int efe);
      int ht, vt;
      ht  = hv + hf + hsw + hb;
      vt  = vv + vf + vsw + vb;
      eh  = k % ht;
      ev  = (k / ht) % vt;
      ehs = (eh >= hv + hf && eh < hv + hf + hsw) ? 0 : 1;
      evs = (ev >= vv + vf && ev < vv + vf + vsw) ? 0 : 1;
      ebl = (eh < hv && ev < vv) ? 0 : 1;
      ele = (eh == ht - 1) ? 1 : 0;
      efe = (eh == ht - 1 && ev == vt - 1) ? 1 : 0;
   endtask

   task automatic set_rst(input int inst, input logic val);
      if (inst == 0) rst_d = val; else rst_r = val;
   endtask

   // One reset edge, then release; returns at the negedge showing the reset state.
   task automatic pulse_reset(input int inst);
      @(negedge clk_25);
      set_rst(inst, 1'b1);
      @(negedge clk_25);
      set_rst(inst, 1'b0);
   endtask

   initial begin
      int eh, ev, ehs, evs, ebl, ele, efe;
      int k_d, k_r, gap, seen;

      // Default geometry: line 0 horizontal sweep and wrap into line 1.
      add(0,   0,   0, 0, 1, 1, 0, 0, 0);
      add(0, 639, 639, 0, 1, 1, 0, 0, 0);
      add(0, 640, 640, 0, 1, 1, 1, 0, 0);
      add(0, 655, 655, 0, 1, 1, 1, 0, 0);
      add(0, 656, 656, 0, 0, 1, 1, 0, 0);
      add(0, 751, 751, 0, 0, 1, 1, 0, 0);
      add(0, 752, 752, 0, 1, 1, 1, 0, 0);
      add(0, 799, 799, 0, 1, 1, 1, 1, 0);
      add(0, 800,   0, 1, 1, 1, 0, 0, 0);
      // Reduced geometry: every phase boundary and the frame wrap.
      add(1,   0, 0, 0, 1, 1, 0, 0, 0);
      add(1,   3, 3, 0, 1, 1, 0, 0, 0);
      add(1,   4, 4, 0, 1, 1, 1, 0, 0);
      add(1,   5, 5, 0, 0, 1, 1, 0, 0);
      add(1,   6, 6, 0, 0, 1, 1, 0, 0);
      add(1,   7, 7, 0, 1, 1, 1, 1, 0);
      add(1,   8, 0, 1, 1, 1, 0, 0, 0);
      add(1,  16, 0, 2, 1, 1, 1, 0, 0);
      add(1,  24, 0, 3, 1, 0, 1, 0, 0);
      add(1,  31, 7, 3, 1, 0, 1, 1, 0);
      add(1,  32, 0, 4, 1, 1, 1, 0, 0);
      add(1,  39, 7, 4, 1, 1, 1, 1, 1);
      add(1,  40, 0, 0, 1, 1, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         pulse_reset(vecs[i].inst);
         repeat (vecs[i].n) @(negedge clk_25);
         check_all($sformatf("vec%0d", i), vecs[i].inst, vecs[i].h, vecs[i].v,
                   vecs[i].hs, vecs[i].vs, vecs[i].bl, vecs[i].le, vecs[i].fe);
      end

      // Reset held for several edges from mid-frame keeps the reset values.
      pulse_reset(1);
      repeat (13) @(negedge clk_25);
      rst_r = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_25);
         check_all($sformatf("hold%0d", i), 1, 0, 0, 1, 1, 0, 0, 0);
      end
      rst_r = 1'b0;
      @(negedge clk_25);
      check_all("hold_rel", 1, 1, 0, 1, 1, 0, 0, 0);

      // Reduced frame period measured between consecutive frame_end pulses.
      seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
         @(negedge clk_25);
         if (fe_r) seen = 1;
      end
      chk("fe_first_seen", seen, 1);
      gap = 0; seen = 0;
      for (int i = 0; i < 200 && seen == 0; i++) begin
         @(negedge clk_25);
         gap++;
         if (fe_r) seen = 1;
      end
      chk("fe_second_seen", seen, 1);
      chk("frame_period_r", gap, 40);

      // Default geometry: reset mid-line at (300,2), then resume counting from the origin.
      pulse_reset(0);
      repeat (2 * 800 + 300) @(negedge clk_25);
      check_all("pre_mid", 0, 300, 2, 1, 1, 0, 0, 0);
      rst_d = 1'b1;
      @(negedge clk_25);
      rst_d = 1'b0;
      check_all("mid_rst", 0, 0, 0, 1, 1, 0, 0, 0);
      repeat (801) @(negedge clk_25);
      check_all("mid_after", 0, 1, 1, 1, 1, 0, 0, 0);

      // Random reset pulses on both instances, compared every cycle against the model.
      rst_d = 1'b1; rst_r = 1'b1;
      k_d = 0; k_r = 0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk_25);
         k_d = rst_d ? 0 : k_d + 1;
         k_r = rst_r ? 0 : k_r + 1;
         model(k_d, 640, 16, 96, 48, 480, 10, 2, 33, eh, ev, ehs, evs, ebl, ele, efe);
         check_all("rnd_d", 0, eh, ev, ehs, evs, ebl, ele, efe);
         model(k_r, R_HVID, R_HFP, R_HSW, R_HBP, R_VVID, R_VFP, R_VSW, R_VBP,
               eh, ev, ehs, evs, ebl, ele, efe);
         check_all("rnd_r", 1, eh, ev, ehs, evs, ebl, ele, efe);
         rst_d = ($urandom_range(0, 999) == 0);
         rst_r = ($urandom_range(0, 59) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
